// File: rtl/taylor_trig_engine.sv
// Maclaurin-series cos/sin engine: one shared multiplier sequenced by an FSM,
// alternating-sign accumulator, constant coefficient LUT and magnitude-based early stop.
module taylor_trig_engine #(
    parameter int DATA_W  = 16,
    parameter int COEF_W  = 16,
    parameter int N_TERMS = 4,
    parameter int THR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic              mode,
    input  logic [THR_W-1:0]  thr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        terms_used
);

    localparam int MW = (DATA_W > COEF_W) ? DATA_W : COEF_W;
    localparam int PW = DATA_W + 1 + MW;
    localparam int TW = (DATA_W > THR_W) ? DATA_W : THR_W;
    localparam logic [2:0]              K_LAST  = 3'(N_TERMS - 1);
    localparam logic [DATA_W:0]         P_ONE   = {1'b1, {DATA_W{1'b0}}};
    localparam logic signed [DATA_W+1:0] ACC_ONE = {2'b01, {DATA_W{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SQ, S_POW, S_MUL, S_ACC, S_DONE} state_t;

    // round(2^COEF_W / n!), n = 2k for cos and 2k+1 for sin; evaluated at elaboration only.
    function automatic logic [COEF_W-1:0] coef_f(input logic sin_sel, input int k);
        logic [63:0] fact;
        int          n;
        n    = 2 * k + (sin_sel ? 1 : 0);
        fact = 64'd1;
        for (int i = 2; i <= n; i++) fact = fact * 64'(i);
        return COEF_W'(((64'd1 << COEF_W) + (fact >> 1)) / fact);
    endfunction

    logic [COEF_W-1:0] coef_lut [2][8];
    for (genvar m = 0; m < 2; m++) begin : g_mode
        for (genvar k = 0; k < 8; k++) begin : g_term
            assign coef_lut[m][k] = coef_f(1'(m), k);
        end
    end

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     x_q, x_d, x2_q, x2_d, term_q, term_d, result_q, result_d;
    logic [DATA_W:0]       p_q, p_d;
    logic signed [DATA_W+1:0] acc_q, acc_d, term_s;
    logic [THR_W-1:0]      thr_q, thr_d;
    logic [2:0]            k_q, k_d, terms_q, terms_d;
    logic                  mode_q, mode_d, sgn_q, sgn_d;
    logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [DATA_W:0]       mul_a;
    logic [MW-1:0]         mul_b;
    logic [PW-1:0]         prod;

    always_comb begin
        mul_a = p_q;
        mul_b = MW'(x2_q);
        case (state_q)
            S_SQ: begin
                mul_a = {1'b0, x_q};
                mul_b = MW'(x_q);
            end
            S_MUL:   mul_b = MW'(coef_lut[mode_q][k_q]);
            default: ;
        endcase
        prod = PW'(mul_a) * PW'(mul_b);
    end

    assign term_s = $signed({2'b00, term_q});

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        mode_d   = mode_q;
        thr_d    = thr_q;
        x2_d     = x2_q;
        p_d      = p_q;
        term_d   = term_q;
        acc_d    = acc_q;
        k_d      = k_q;
        sgn_d    = sgn_q;
        terms_d  = terms_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = x;
                    mode_d  = mode;
                    thr_d   = thr;
                    state_d = S_SQ;
                end
            end
            S_SQ: begin
                x2_d    = DATA_W'(prod >> DATA_W);
                k_d     = 3'd1;
                sgn_d   = 1'b1;
                p_d     = mode_q ? {1'b0, x_q} : P_ONE;
                acc_d   = mode_q ? $signed({2'b00, x_q}) : ACC_ONE;
                state_d = S_POW;
            end
            S_POW: begin
                p_d     = (DATA_W + 1)'(prod >> DATA_W);
                state_d = S_MUL;
            end
            S_MUL: begin
                term_d  = DATA_W'(prod >> COEF_W);
                state_d = S_ACC;
            end
            S_ACC: begin
                acc_d   = sgn_q ? (acc_q - term_s) : (acc_q + term_s);
                sgn_d   = ~sgn_q;
                terms_d = k_q;
                // The term that satisfies the threshold has already been folded into acc_d.
                if (k_q == K_LAST || TW'(term_q) < TW'(thr_q)) begin
                    result_d = acc_d[DATA_W+1:2];
                    state_d  = S_DONE;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = S_POW;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            mode_q      <= 1'b0;
            thr_q       <= '0;
            x2_q        <= '0;
            p_q         <= '0;
            term_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            sgn_q       <= 1'b0;
            terms_q     <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            mode_q      <= mode_d;
            thr_q       <= thr_d;
            x2_q        <= x2_d;
            p_q         <= p_d;
            term_q      <= term_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            sgn_q       <= sgn_d;
            terms_q     <= terms_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign terms_used = terms_q;

endmodule
